// File: rtl/fetch_pkg.sv
// Shared fetch definitions: FSM state encoding and default widths
// used by the fetch unit and the PC register.
package fetch_pkg;

    localparam int INSTR_ADDR_W = 12;
    localparam int INSTR_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: reads the word at the PC address from memory, holds it
// for the decoder, and advances the PC only once the decoder accepts it.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = INSTR_ADDR_W,
    parameter int DATA_WIDTH = INSTR_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] currentAddress,
    output logic                  pc_advance,
    input  logic                  flush,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_addr
);

    fetch_state_t          state_q;
    fetch_state_t          state_d;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic                  req_fire;
    logic                  capture;

    assign req_fire = (state_q == REQ) && mem_req_ready;
    assign capture  = (state_q == WAIT) && mem_rsp_valid && !flush;

    assign mem_req_addr = currentAddress;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        instr_valid   = 1'b0;
        pc_advance    = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = flush ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = flush ? REQ : HOLD;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_rsp_valid) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                // A redirect drops the held word without advancing the PC.
                if (flush) begin
                    state_d = REQ;
                end else if (instr_ready) begin
                    pc_advance = 1'b1;
                    state_d    = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_addr  <= '0;
            instr_data <= '0;
            instr_addr <= '0;
        end else begin
            if (req_fire) begin
                pend_addr <= currentAddress;
            end
            if (capture) begin
                instr_data <= mem_rsp_data;
                instr_addr <= pend_addr;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: the bench plays PC, memory
// and decoder cycle by cycle and checks outputs at the falling edge.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic [11:0] cur_addr;
    logic        pc_advance;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [11:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [11:0] instr_addr;

    logic [11:0] flush_tgt;
    logic        s_req;
    logic        s_iv;
    logic        s_adv;
    logic [11:0] s_raddr;
    logic [31:0] s_data;
    logic [11:0] s_addr;

    int vecs;
    int errs;

    instruction_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .currentAddress(cur_addr),
        .pc_advance    (pc_advance),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_addr    (instr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Sample outputs mid-cycle, then act as the PC on the next rising edge.
    task automatic step();
        @(negedge clk);
        s_req   = mem_req_valid;
        s_iv    = instr_valid;
        s_adv   = pc_advance;
        s_raddr = mem_req_addr;
        s_data  = instr_data;
        s_addr  = instr_addr;
        @(posedge clk);
        #1;
        if (flush) cur_addr = flush_tgt;
        else if (s_adv) cur_addr = cur_addr + 12'd4;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        instr_ready = 1'b1;
        flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cur_addr = 12'h000;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cur_addr = 12'h000;
        flush = 1'b0;
        flush_tgt = 12'h000;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = 32'h0;
        instr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({mem_req_valid, instr_valid, pc_advance} !== 3'b000) begin
            errs++;
            $display("FAIL reset_ctl got %b exp 000",
                     {mem_req_valid, instr_valid, pc_advance});
        end
        vecs++;
        if (instr_data !== 32'h0 || instr_addr !== 12'h0) begin
            errs++;
            $display("FAIL reset_regs got %h/%h exp 0/0", instr_data, instr_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        vecs++;
        if (s_req !== 1'b0) begin
            errs++;
            $display("FAIL idle_req got %b exp 0", s_req);
        end
        step();
        vecs++;
        if (s_req !== 1'b1 || s_raddr !== 12'h000) begin
            errs++;
            $display("FAIL first_req got %b/%h exp 1/000", s_req, s_raddr);
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'h2008_0005;
        step();
        vecs++;
        if (s_iv !== 1'b0 || s_req !== 1'b0) begin
            errs++;
            $display("FAIL first_wait got iv=%b req=%b exp 0/0", s_iv, s_req);
        end
        mem_rsp_valid = 1'b0;
        step();
        vecs++;
        if (s_iv !== 1'b1 || s_adv !== 1'b1 || s_data !== 32'h2008_0005
            || s_addr !== 12'h000) begin
            errs++;
            $display("FAIL first_instr got iv=%b adv=%b %h@%h exp 1/1 20080005@000",
                     s_iv, s_adv, s_data, s_addr);
        end
        step();
        vecs++;
        if (s_adv !== 1'b0 || s_req !== 1'b1 || s_raddr !== 12'h004) begin
            errs++;
            $display("FAIL after_adv got adv=%b req=%b a=%h exp 0/1/004",
                     s_adv, s_req, s_raddr);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_a;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_a = 12'(i * 4);
            mem_req_ready = 1'b1;
            mem_rsp_valid = 1'b0;
            step();
            vecs++;
            if (s_req !== 1'b1 || s_raddr !== exp_a || s_iv !== 1'b0) begin
                errs++;
                $display("FAIL b2b_req%0d got req=%b a=%h exp 1/%h",
                         i, s_req, s_raddr, exp_a);
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_data = 32'hA000_0000 | 32'(exp_a);
            step();
            mem_rsp_valid = 1'b0;
            step();
            vecs++;
            if (s_iv !== 1'b1 || s_adv !== 1'b1 || s_addr !== exp_a
                || s_data !== (32'hA000_0000 | 32'(exp_a))) begin
                errs++;
                $display("FAIL b2b_instr%0d got iv=%b adv=%b %h@%h exp 1/1 @%h",
                         i, s_iv, s_adv, s_data, s_addr, exp_a);
            end
        end
    endtask

    task automatic test_flush_wait();
        mem_req_ready = 1'b1;
        step();
        vecs++;
        if (s_req !== 1'b1 || s_raddr !== 12'h010) begin
            errs++;
            $display("FAIL fw_req got %b/%h exp 1/010", s_req, s_raddr);
        end
        mem_req_ready = 1'b0;
        flush = 1'b1;
        flush_tgt = 12'h120;
        step();
        flush = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'hDEAD_0010;
        step();
        vecs++;
        if (s_iv !== 1'b0 || s_req !== 1'b0) begin
            errs++;
            $display("FAIL fw_drain got iv=%b req=%b exp 0/0", s_iv, s_req);
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        vecs++;
        if (s_iv !== 1'b0 || s_req !== 1'b1 || s_raddr !== 12'h120) begin
            errs++;
            $display("FAIL fw_refetch got iv=%b req=%b a=%h exp 0/1/120",
                     s_iv, s_req, s_raddr);
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'hA000_0120;
        step();
        mem_rsp_valid = 1'b0;
        step();
        vecs++;
        if (s_iv !== 1'b1 || s_addr !== 12'h120 || s_data !== 32'hA000_0120) begin
            errs++;
            $display("FAIL fw_instr got iv=%b %h@%h exp 1 a0000120@120",
                     s_iv, s_data, s_addr);
        end
    endtask

    task automatic test_backpressure();
        int advs;
        advs = 0;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            vecs++;
            if (s_req !== 1'b1 || s_raddr !== 12'h124) begin
                errs++;
                $display("FAIL bp_reqwait%0d got %b/%h exp 1/124", i, s_req, s_raddr);
            end
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++;
            if (s_req !== 1'b0 || s_iv !== 1'b0) begin
                errs++;
                $display("FAIL bp_rspwait%0d got req=%b iv=%b exp 0/0", i, s_req, s_iv);
            end
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'h8C09_0124;
        step();
        mem_rsp_valid = 1'b0;
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (s_adv) advs++;
            vecs++;
            if (s_iv !== 1'b1 || s_data !== 32'h8C09_0124 || s_addr !== 12'h124) begin
                errs++;
                $display("FAIL bp_hold%0d got iv=%b %h@%h exp 1 8c090124@124",
                         i, s_iv, s_data, s_addr);
            end
        end
        instr_ready = 1'b1;
        step();
        if (s_adv) advs++;
        step();
        if (s_adv) advs++;
        vecs++;
        if (advs !== 1 || s_req !== 1'b1 || s_raddr !== 12'h128) begin
            errs++;
            $display("FAIL bp_advance got advs=%0d req=%b a=%h exp 1/1/128",
                     advs, s_req, s_raddr);
        end
    endtask

    task automatic test_flush_hold();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'hA000_0128;
        step();
        mem_rsp_valid = 1'b0;
        instr_ready = 1'b1;
        flush = 1'b1;
        flush_tgt = 12'h200;
        step();
        vecs++;
        if (s_iv !== 1'b1 || s_adv !== 1'b0) begin
            errs++;
            $display("FAIL fh_noadv got iv=%b adv=%b exp 1/0", s_iv, s_adv);
        end
        flush = 1'b0;
        step();
        vecs++;
        if (s_req !== 1'b1 || s_raddr !== 12'h200 || s_iv !== 1'b0) begin
            errs++;
            $display("FAIL fh_refetch got req=%b a=%h iv=%b exp 1/200/0",
                     s_req, s_raddr, s_iv);
        end
    endtask

    task automatic test_flush_rsp();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'hBAD0_0200;
        flush = 1'b1;
        flush_tgt = 12'h300;
        step();
        flush = 1'b0;
        mem_rsp_valid = 1'b0;
        step();
        vecs++;
        if (s_req !== 1'b1 || s_iv !== 1'b0 || s_raddr !== 12'h300
            || s_data !== 32'hA000_0128) begin
            errs++;
            $display("FAIL fr_drop got req=%b iv=%b a=%h d=%h exp 1/0/300/a0000128",
                     s_req, s_iv, s_raddr, s_data);
        end
    endtask

    task automatic test_mid_reset();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        vecs++;
        if ({mem_req_valid, instr_valid, pc_advance} !== 3'b000
            || instr_data !== 32'h0 || instr_addr !== 12'h0) begin
            errs++;
            $display("FAIL mid_reset got %b %h@%h exp 000 0@0",
                     {mem_req_valid, instr_valid, pc_advance}, instr_data, instr_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        cur_addr = 12'h040;
        step();
        mem_req_ready = 1'b1;
        step();
        vecs++;
        if (s_req !== 1'b1 || s_raddr !== 12'h040) begin
            errs++;
            $display("FAIL mr_req got %b/%h exp 1/040", s_req, s_raddr);
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'hA000_0040;
        step();
        mem_rsp_valid = 1'b0;
        step();
        vecs++;
        if (s_iv !== 1'b1 || s_adv !== 1'b1 || s_addr !== 12'h040
            || s_data !== 32'hA000_0040) begin
            errs++;
            $display("FAIL mr_instr got iv=%b adv=%b %h@%h exp 1/1 a0000040@040",
                     s_iv, s_adv, s_data, s_addr);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_back_to_back();
        test_flush_wait();
        test_backpressure();
        test_flush_hold();
        test_flush_rsp();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
